// File: rtl/scr1_dmem_router_mp_pkg.sv
// Shared memory-interface types and sizing constants for the DMEM router.
// Encodings match the core-side memory interface definitions.
package scr1_dmem_router_mp_pkg;

  localparam int SCR1_DMEM_AWIDTH      = 32;
  localparam int SCR1_DMEM_DWIDTH      = 32;
  localparam int SCR1_DMEM_RT_PORT_MAX = 8;
  localparam int SCR1_RT_IDX_W         = $clog2(SCR1_DMEM_RT_PORT_MAX + 1);

  // Index wide enough for every slave port plus the internal error target.
  typedef logic [SCR1_RT_IDX_W-1:0] type_scr1_rt_idx;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Pointer width for a ring of 'depth' entries; a single-entry ring still needs one bit.
  function automatic int rt_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scr1_router_sel_fifo.sv
// Small synchronous FIFO holding the routing target of each accepted request.
// Exposes the oldest entry (head), the most recently pushed value (tail) and the fill count.
module scr1_router_sel_fifo
  import scr1_dmem_router_mp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  localparam int              PTR_W    = rt_ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every always_comb output is given a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tail_d   = tail_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      tail_d   = push_data;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tail_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tail_q   <= tail_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read while cnt says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign tail  = tail_q;
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/scr1_dmem_router_mp.sv
// Routes core DMEM requests to one of N slave ports by mask/pattern decode, with
// pipelined outstanding requests and in-order responses; unmapped addresses answer RDY_ER.
module scr1_dmem_router_mp
  import scr1_dmem_router_mp_pkg::*;
#(
  parameter int SCR1_PORT_NUM  = 3,
  parameter int SCR1_MAX_OUTST = 2,
  parameter logic [SCR1_PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] SCR1_ADDR_MASK =
    {SCR1_PORT_NUM{32'hFFFF_0000}},
  parameter logic [SCR1_PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] SCR1_ADDR_PATTERN =
    {32'h0002_0000, 32'h0001_0000, 32'h0000_0000}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // Core side
  input  logic                        dmem_req,
  output logic                        dmem_req_ack,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  // Slave side
  output logic [SCR1_PORT_NUM-1:0]    port_req,
  input  logic [SCR1_PORT_NUM-1:0]    port_req_ack,
  output type_scr1_mem_cmd_e          port_cmd,
  output type_scr1_mem_width_e        port_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] port_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] port_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0] port_rdata [SCR1_PORT_NUM],
  input  type_scr1_mem_resp_e         port_resp  [SCR1_PORT_NUM]
);

  localparam int               IDX_W     = $clog2(SCR1_PORT_NUM + 1);
  localparam int               CNT_W     = $clog2(SCR1_MAX_OUTST + 1);
  localparam logic [IDX_W-1:0] ERR_IDX   = IDX_W'(SCR1_PORT_NUM);
  localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(SCR1_MAX_OUTST);

  logic [IDX_W-1:0]            tgt;
  logic [IDX_W-1:0]            fifo_head;
  logic [IDX_W-1:0]            fifo_tail;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [CNT_W-1:0]            eff_cnt;
  logic                        fifo_empty;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        eff_empty;
  logic                        allow;
  logic                        tgt_ack;
  type_scr1_mem_resp_e         sel_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;

  // Lowest matching port wins, so the scan runs high-to-low and the last hit sticks.
  always_comb begin
    tgt = ERR_IDX;
    for (int i = SCR1_PORT_NUM - 1; i >= 0; i--) begin
      if ((dmem_addr & SCR1_ADDR_MASK[i]) == SCR1_ADDR_PATTERN[i]) begin
        tgt = IDX_W'(i);
      end
    end
  end

  // Head response source; the error target answers by itself.
  always_comb begin
    sel_resp  = SCR1_MEM_RESP_RDY_ER;
    sel_rdata = '0;
    for (int i = 0; i < SCR1_PORT_NUM; i++) begin
      if (fifo_head == IDX_W'(i)) begin
        sel_resp  = port_resp[i];
        sel_rdata = port_rdata[i];
      end
    end
  end

  always_comb begin
    fifo_pop  = !fifo_empty && (sel_resp != SCR1_MEM_RESP_NOTRDY);
    eff_cnt   = fifo_cnt - CNT_W'(fifo_pop);
    eff_empty = (eff_cnt == '0);
    // Only one target may be in flight at a time; that is what keeps responses in order.
    allow     = (eff_cnt < OUTST_MAX) && (eff_empty || (tgt == fifo_tail));

    tgt_ack = (tgt == ERR_IDX);
    for (int i = 0; i < SCR1_PORT_NUM; i++) begin
      if (tgt == IDX_W'(i)) begin
        tgt_ack = port_req_ack[i];
      end
    end
    dmem_req_ack = allow && tgt_ack;
    fifo_push    = dmem_req && dmem_req_ack;

    port_req = '0;
    for (int i = 0; i < SCR1_PORT_NUM; i++) begin
      port_req[i] = dmem_req && allow && (tgt == IDX_W'(i));
    end

    if (fifo_empty) begin
      dmem_resp  = SCR1_MEM_RESP_NOTRDY;
      dmem_rdata = '0;
    end else begin
      dmem_resp  = sel_resp;
      dmem_rdata = sel_rdata;
    end
  end

  assign port_cmd   = dmem_cmd;
  assign port_width = dmem_width;
  assign port_addr  = dmem_addr;
  assign port_wdata = dmem_wdata;

  scr1_router_sel_fifo #(
    .DEPTH (SCR1_MAX_OUTST),
    .WIDTH (IDX_W),
    .CNT_W (CNT_W)
  ) u_sel_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (tgt),
    .head      (fifo_head),
    .tail      (fifo_tail),
    .cnt       (fifo_cnt),
    .empty     (fifo_empty)
  );

`ifdef SCR1_SYN_OFF_EN
  a_no_x_on_req: assert property (@(posedge clk) disable iff (!rst_n)
    dmem_req |-> !$isunknown({dmem_cmd, dmem_width, dmem_addr}));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> ((fifo_cnt < OUTST_MAX) || fifo_pop));
  a_port_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(port_req));
  for (genvar g = 0; g < SCR1_PORT_NUM; g++) begin : g_resp_chk
    a_no_resp_empty: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_empty |-> (port_resp[g] == SCR1_MEM_RESP_NOTRDY));
  end
`endif

endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
// Randomized and directed bench for scr1_dmem_router_mp against a queue-based model
// of the routing rules, with simple behavioural slaves answering after a set latency.
module tb_scr1_dmem_router_mp;
  import scr1_dmem_router_mp_pkg::*;

  localparam int PN = 3;
  localparam int MO = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 dmem_req;
  logic                 dmem_req_ack;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic [PN-1:0]        port_req;
  logic [PN-1:0]        port_req_ack;
  type_scr1_mem_cmd_e   port_cmd;
  type_scr1_mem_width_e port_width;
  logic [31:0]          port_addr;
  logic [31:0]          port_wdata;
  logic [31:0]          port_rdata [PN];
  type_scr1_mem_resp_e  port_resp  [PN];

  scr1_dmem_router_mp #(
    .SCR1_PORT_NUM  (PN),
    .SCR1_MAX_OUTST (MO)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req     (dmem_req),
    .dmem_req_ack (dmem_req_ack),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .port_req     (port_req),
    .port_req_ack (port_req_ack),
    .port_cmd     (port_cmd),
    .port_width   (port_width),
    .port_addr    (port_addr),
    .port_wdata   (port_wdata),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        er;
    logic [31:0] data;
  } slv_ent_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  string       phase   = "init";
  int          q_tgt[$];
  slv_ent_t    sq [PN][$];
  bit          auto_slave = 1'b0;
  int          er_pct  = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] data_seq = '0;

  logic                act_ack;
  logic [PN-1:0]       act_preq;
  type_scr1_mem_resp_e act_resp;
  logic [31:0]         act_rdata;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h (cycle %0d)", phase, tag, act, expv, cyc);
    end
  endtask

  // Address map: port i owns the 64 KiB window starting at i*0x10000; anything else is unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < PN; i++) begin
      if ((a & 32'hFFFF_0000) == 32'(i) * 32'h0001_0000) return i;
    end
    return PN;
  endfunction

  task automatic idle();
    dmem_req     = 1'b0;
    dmem_cmd     = SCR1_MEM_CMD_RD;
    dmem_width   = SCR1_MEM_WIDTH_WORD;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    port_req_ack = '0;
    for (int i = 0; i < PN; i++) begin
      port_resp[i]  = SCR1_MEM_RESP_NOTRDY;
      port_rdata[i] = '0;
    end
  endtask

  // One clock cycle: drive slaves, compare every output with the model, then advance the model.
  task automatic step();
    int                  n, tgt, eff, head;
    bit                  allow, exp_ack, exp_pop;
    logic [PN-1:0]       exp_preq;
    type_scr1_mem_resp_e exp_resp;
    logic [31:0]         exp_rdata;
    slv_ent_t            e;
    @(negedge clk);
    if (auto_slave) begin
      for (int i = 0; i < PN; i++) begin
        if (sq[i].size() > 0 && cyc >= sq[i][0].due) begin
          port_resp[i]  = sq[i][0].er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
          port_rdata[i] = sq[i][0].data;
        end else begin
          port_resp[i]  = SCR1_MEM_RESP_NOTRDY;
          port_rdata[i] = $urandom;
        end
      end
    end
    #1;
    tgt       = decode(dmem_addr);
    n         = q_tgt.size();
    head      = -1;
    exp_resp  = SCR1_MEM_RESP_NOTRDY;
    exp_rdata = '0;
    if (n > 0) begin
      head = q_tgt[0];
      if (head == PN) exp_resp = SCR1_MEM_RESP_RDY_ER;
      else begin
        exp_resp  = port_resp[head];
        exp_rdata = port_rdata[head];
      end
    end
    exp_pop = (n > 0) && (exp_resp != SCR1_MEM_RESP_NOTRDY);
    eff     = n - int'(exp_pop);
    allow   = (eff < MO);
    if (allow && eff > 0 && tgt != q_tgt[n-1]) allow = 1'b0;
    exp_ack = 1'b0;
    if (allow) exp_ack = (tgt == PN) ? 1'b1 : port_req_ack[tgt];
    exp_preq = '0;
    if (dmem_req && allow && tgt < PN) exp_preq[tgt] = 1'b1;

    act_ack   = dmem_req_ack;
    act_preq  = port_req;
    act_resp  = dmem_resp;
    act_rdata = dmem_rdata;
    check("req_ack",  act_ack,  exp_ack);
    check("port_req", act_preq, exp_preq);
    check("resp",     act_resp, exp_resp);
    check("rdata",    act_rdata, exp_rdata);
    check("cnt",      u_dut.fifo_cnt, n);

    @(posedge clk);
    if (exp_pop) begin
      void'(q_tgt.pop_front());
      if (auto_slave && head < PN && sq[head].size() > 0) void'(sq[head].pop_front());
    end
    if (dmem_req && exp_ack) q_tgt.push_back(tgt);
    if (auto_slave) begin
      for (int i = 0; i < PN; i++) begin
        if (act_preq[i] && port_req_ack[i]) begin
          e.due  = cyc + int'($urandom_range(lat_max, lat_min));
          e.er   = ($urandom_range(99) < er_pct);
          e.data = data_seq;
          data_seq++;
          sq[i].push_back(e);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic req_to(input logic [31:0] addr, input logic [PN-1:0] ack);
    idle();
    dmem_req     = 1'b1;
    dmem_addr    = addr;
    port_req_ack = ack;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int          ack_c[$];
    int          pop_c[$];
    logic [31:0] rd[$];
    int          sent;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    phase = "reset_state";
    step();

    phase = "single_read";
    req_to(32'h0001_0004, 3'b010);
    step();
    check("t1_port_req", act_preq, 3'b010);
    idle();
    port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[1] = 32'hCAFE_0001;
    step();
    check("t1_rdata", act_rdata, 32'hCAFE_0001);
    idle();
    step();

    phase = "target_switch";
    req_to(32'h0001_0000, 3'b010);
    step();
    req_to(32'h0002_0000, 3'b100);
    step();
    check("t3_held", act_preq, 3'b000);
    req_to(32'h0002_0000, 3'b100);
    port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[1] = 32'h1111_0000;
    step();
    check("t3_issue", act_preq, 3'b100);
    check("t3_ack", act_ack, 1'b1);
    idle();
    port_resp[2]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[2] = 32'h2222_0000;
    step();
    idle();
    step();

    phase = "unmapped";
    req_to(32'hF000_0000, 3'b000);
    step();
    check("t4_ack", act_ack, 1'b1);
    check("t4_no_req", act_preq, 3'b000);
    req_to(32'h0000_0010, 3'b001);
    step();
    check("t4_er", act_resp, SCR1_MEM_RESP_RDY_ER);
    check("t4_next_req", act_preq, 3'b001);
    idle();
    port_resp[0]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[0] = 32'h0000_ABCD;
    step();
    check("t4_next_ok", act_resp, SCR1_MEM_RESP_RDY_OK);
    idle();
    step();

    phase = "slave_error";
    req_to(32'h0002_0000, 3'b100);
    step();
    req_to(32'h0002_0008, 3'b100);
    step();
    idle();
    port_resp[2] = SCR1_MEM_RESP_RDY_ER;
    step();
    check("t5_first_er", act_resp, SCR1_MEM_RESP_RDY_ER);
    idle();
    port_resp[2]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[2] = 32'h5555_AAAA;
    step();
    check("t5_second_ok", act_resp, SCR1_MEM_RESP_RDY_OK);
    idle();
    step();
    check("t5_cnt_zero", u_dut.fifo_cnt, 0);

    phase = "async_reset";
    req_to(32'h0001_0000, 3'b010);
    step();
    req_to(32'h0001_0004, 3'b010);
    step();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_resp",  dmem_resp,  SCR1_MEM_RESP_NOTRDY);
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_cnt",   u_dut.fifo_cnt, 0);
    check("rst_preq",  port_req,   3'b000);
    q_tgt.delete();
    for (int i = 0; i < PN; i++) sq[i].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc += 2;
    #1;
    idle();
    port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
    port_rdata[1] = 32'hDEAD_BEEF;
    step();
    check("rst_late_ignored", act_resp, SCR1_MEM_RESP_NOTRDY);
    req_to(32'h0000_0020, 3'b001);
    step();
    check("rst_new_ack", act_ack, 1'b1);
    idle();
    port_resp[0] = SCR1_MEM_RESP_RDY_OK;
    step();
    idle();
    step();

    phase      = "back_to_back";
    auto_slave = 1'b1;
    lat_min    = 2;
    lat_max    = 2;
    er_pct     = 0;
    data_seq   = 32'hD000_0000;
    sent       = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      dmem_req     = (sent < 4);
      dmem_addr    = 32'(sent * 4);
      port_req_ack = '1;
      step();
      if (dmem_req && act_ack) begin
        ack_c.push_back(c);
        sent++;
      end
      if (act_resp != SCR1_MEM_RESP_NOTRDY) begin
        pop_c.push_back(c);
        rd.push_back(act_rdata);
      end
    end
    check("b2b_acks", ack_c.size(), 4);
    check("b2b_pops", pop_c.size(), 4);
    if (ack_c.size() >= 3 && pop_c.size() >= 1) begin
      check("b2b_third_ack_cycle", ack_c[2], 2);
      check("b2b_first_pop_cycle", pop_c[0], 2);
    end
    for (int k = 0; k < rd.size(); k++) begin
      check("b2b_order", rd[k], 32'hD000_0000 + 32'(k));
    end

    phase   = "random";
    lat_min = 1;
    lat_max = 3;
    er_pct  = 15;
    for (int c = 0; c < 600; c++) begin
      int r;
      idle();
      r            = int'($urandom_range(7));
      dmem_req     = ($urandom_range(99) < 70);
      dmem_cmd     = type_scr1_mem_cmd_e'($urandom_range(1));
      dmem_width   = type_scr1_mem_width_e'($urandom_range(2));
      dmem_wdata   = $urandom;
      port_req_ack = PN'($urandom);
      if (r < 2) dmem_addr = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
      else       dmem_addr = (32'(r % 3) * 32'h0001_0000) | ($urandom & 32'h0000_FFFC);
      step();
    end
    phase = "drain";
    for (int c = 0; c < 12; c++) begin
      idle();
      step();
    end
    check("drain_empty", u_dut.fifo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
